// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_pkg;

  typedef enum logic [2:0] {
    RUN        = 3'd0,
    MEM_WAIT   = 3'd1,
    ACCEL_WAIT = 3'd2,
    SPART_WAIT = 3'd3,
    REDIRECT   = 3'd4
  } pipe_state_e;

  // Register 0 is hard-wired zero and never creates a dependency.
  localparam int REG_ZERO = 0;

  // Arbitration order, lower value wins.
  localparam int PRIO_MEM      = 0;
  localparam int PRIO_REDIRECT = 1;
  localparam int PRIO_SPART    = 2;
  localparam int PRIO_ACCEL    = 3;
  localparam int PRIO_LOAD_USE = 4;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID source that depends on a load currently in EX.
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic [REG_AW-1:0] id_p0_addr,
  input  logic [REG_AW-1:0] id_p1_addr,
  input  logic              id_p0_used,
  input  logic              id_p1_used,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic              ex_mem_re,
  input  logic              ex_we,
  output logic              load_use
);

  logic p0_hit;
  logic p1_hit;
  logic dst_nonzero;

  assign p0_hit      = id_p0_used & (id_p0_addr == ex_dst_addr);
  assign p1_hit      = id_p1_used & (id_p1_addr == ex_dst_addr);
  assign dst_nonzero = (ex_dst_addr != REG_AW'(REG_ZERO));
  assign load_use    = ex_mem_re & ex_we & (p0_hit | p1_hit) & dst_nonzero;

endmodule

// File: rtl/pipe_ctrl.sv
// Prioritised hazard/sequencing controller for the 4-stage pipeline.
// Optional PIPE_CTRL_STATS_EN adds saturating stall_cnt / flush_cnt outputs.
//
// state      | meaning
// RUN        | normal issue, load-use detection active
// MEM_WAIT   | data memory busy, whole front end and EX/MEM frozen
// ACCEL_WAIT | ID waits on busy accelerator, bubble into EX
// SPART_WAIT | EX send blocked by full SPART TX FIFO
// REDIRECT   | one idle cycle after a flush
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_p0_addr,
  input  logic [REG_AW-1:0] id_p1_addr,
  input  logic              id_p0_used,
  input  logic              id_p1_used,
  input  logic [REG_AW-1:0] ex_dst_addr,
  input  logic              ex_mem_re,
  input  logic              ex_we,
  input  logic              ex_redirect,
  input  logic              mem_wait,
  input  logic              accel_busy,
  input  logic              id_accel_req,
  input  logic              spart_full,
  input  logic              ex_send,
  output logic              pc_hold,
  output logic              if_id_stall,
  output logic              if_id_flush,
  output logic              id_ex_stall,
  output logic              id_ex_flush,
  output logic              ex_mem_stall,
  output logic              mem_err
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  // Counter holds cycles already waited, so the current cycle is the MEM_TIMEOUT-th at this value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  pipe_state_e      state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic             lu_block, lu_nxt;
  logic             load_use;
  logic             hold_c, ifs_c, iff_c, ids_c, idf_c, exs_c, err_c;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_p0_addr  (id_p0_addr),
    .id_p1_addr  (id_p1_addr),
    .id_p0_used  (id_p0_used),
    .id_p1_used  (id_p1_used),
    .ex_dst_addr (ex_dst_addr),
    .ex_mem_re   (ex_mem_re),
    .ex_we       (ex_we),
    .load_use    (load_use)
  );

  always_comb begin
    state_nxt = RUN;
    cnt_nxt   = '0;
    lu_nxt    = 1'b0;
    hold_c    = 1'b0;
    ifs_c     = 1'b0;
    iff_c     = 1'b0;
    ids_c     = 1'b0;
    idf_c     = 1'b0;
    exs_c     = 1'b0;
    err_c     = 1'b0;
    if (mem_wait) begin
      state_nxt = MEM_WAIT;
      {hold_c, ifs_c, ids_c, exs_c} = 4'b1111;
      if (wait_cnt == CNT_LAST) err_c = 1'b1;
      else cnt_nxt = wait_cnt + 1'b1;
    end else if (ex_redirect) begin
      state_nxt = REDIRECT;
      {iff_c, idf_c} = 2'b11;
    end else if (state == REDIRECT) begin
      state_nxt = RUN;
    end else if (ex_send && spart_full) begin
      state_nxt = SPART_WAIT;
      {hold_c, ifs_c, ids_c} = 3'b111;
    end else if (id_accel_req && accel_busy) begin
      state_nxt = ACCEL_WAIT;
      {hold_c, ifs_c, idf_c} = 3'b111;
    end else if (state == RUN && load_use && !lu_block) begin
      // The bubble moves the load out of EX; lu_block covers stimulus that lingers.
      {hold_c, ifs_c, idf_c} = 3'b111;
      lu_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
      lu_block <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      lu_block <= lu_nxt;
    end
  end

  // Reset forces outputs quiet even while mem_wait or other requests are still high.
  assign pc_hold      = hold_c & rst_n;
  assign if_id_stall  = ifs_c  & rst_n;
  assign if_id_flush  = iff_c  & rst_n;
  assign id_ex_stall  = ids_c  & rst_n;
  assign id_ex_flush  = idf_c  & rst_n;
  assign ex_mem_stall = exs_c  & rst_n;
  assign mem_err      = err_c  & rst_n;

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_c && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
      if (idf_c && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] id_p0_addr, id_p1_addr, ex_dst_addr;
  logic       id_p0_used, id_p1_used, ex_mem_re, ex_we, ex_redirect;
  logic       mem_wait, accel_busy, id_accel_req, spart_full, ex_send;
  logic       pc_hold, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_err;
`ifdef PIPE_CTRL_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // {pc_hold, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_err}
  logic [6:0] outs;
  assign outs = {pc_hold, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_err};

  localparam logic [6:0] IDLE   = 7'b0000000;
  localparam logic [6:0] BUBBLE = 7'b1100100;
  localparam logic [6:0] FLUSH  = 7'b0010100;
  localparam logic [6:0] MEMST  = 7'b1101010;
  localparam logic [6:0] MEMERR = 7'b1101011;
  localparam logic [6:0] SPART  = 7'b1101000;

  always #5 clk = ~clk;

  pipe_ctrl #(.REG_AW(4), .MEM_TIMEOUT(15)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_p0_addr   (id_p0_addr),
    .id_p1_addr   (id_p1_addr),
    .id_p0_used   (id_p0_used),
    .id_p1_used   (id_p1_used),
    .ex_dst_addr  (ex_dst_addr),
    .ex_mem_re    (ex_mem_re),
    .ex_we        (ex_we),
    .ex_redirect  (ex_redirect),
    .mem_wait     (mem_wait),
    .accel_busy   (accel_busy),
    .id_accel_req (id_accel_req),
    .spart_full   (spart_full),
    .ex_send      (ex_send),
    .pc_hold      (pc_hold),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_err      (mem_err)
`ifdef PIPE_CTRL_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic clear_inputs();
    id_p0_addr = 4'h0; id_p1_addr = 4'h0; ex_dst_addr = 4'h0;
    id_p0_used = 1'b0; id_p1_used = 1'b0; ex_mem_re = 1'b0; ex_we = 1'b0;
    ex_redirect = 1'b0; mem_wait = 1'b0; accel_busy = 1'b0; id_accel_req = 1'b0;
    spart_full = 1'b0; ex_send = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL reset_outs got %b want %b", outs, IDLE); end
`ifdef PIPE_CTRL_STATS_EN
    n_cmp++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_stats got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_load_use();
    ex_mem_re = 1; ex_we = 1; ex_dst_addr = 4'h3; id_p1_addr = 4'h3; id_p1_used = 1;
    @(negedge clk);
    n_cmp++;
    if (outs !== BUBBLE) begin n_err++; $display("FAIL lu_p1_first got %b want %b", outs, BUBBLE); end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL lu_p1_second got %b want %b", outs, IDLE); end
    next_cycle();
    clear_inputs();
    ex_mem_re = 1; ex_we = 1; ex_dst_addr = 4'h9; id_p0_addr = 4'h9; id_p0_used = 1;
    id_p1_addr = 4'h2; id_p1_used = 1;
    @(negedge clk);
    n_cmp++;
    if (outs !== BUBBLE) begin n_err++; $display("FAIL lu_p0 got %b want %b", outs, BUBBLE); end
    next_cycle();
    clear_inputs();
    ex_mem_re = 1; ex_we = 1; ex_dst_addr = 4'h5; id_p1_addr = 4'h5; id_p1_used = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL lu_unused_src got %b want %b", outs, IDLE); end
    next_cycle();
    id_p1_used = 1; ex_mem_re = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL lu_not_load got %b want %b", outs, IDLE); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_zero_reg();
    ex_mem_re = 1; ex_we = 1; ex_dst_addr = 4'h0; id_p1_addr = 4'h0; id_p1_used = 1;
    id_p0_addr = 4'h0; id_p0_used = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== IDLE) begin n_err++; $display("FAIL zero_reg cyc%0d got %b want %b", i, outs, IDLE); end
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_redirect_accel();
    accel_busy = 1; id_accel_req = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== BUBBLE) begin n_err++; $display("FAIL accel_wait cyc%0d got %b want %b", i, outs, BUBBLE); end
      next_cycle();
    end
    ex_redirect = 1;
    @(negedge clk);
    n_cmp++;
    if (outs !== FLUSH) begin n_err++; $display("FAIL redirect_flush got %b want %b", outs, FLUSH); end
    next_cycle();
    ex_redirect = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL redirect_idle got %b want %b", outs, IDLE); end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (outs !== BUBBLE) begin n_err++; $display("FAIL accel_resume got %b want %b", outs, BUBBLE); end
    next_cycle();
    accel_busy = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL accel_release got %b want %b", outs, IDLE); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_mem_timeout();
    logic [6:0] exp;
    mem_wait = 1;
    for (int i = 1; i <= 20; i++) begin
      exp = (i == 15) ? MEMERR : MEMST;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp) begin n_err++; $display("FAIL mem_wait cyc%0d got %b want %b", i, outs, exp); end
      next_cycle();
    end
    mem_wait = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL mem_release got %b want %b", outs, IDLE); end
    next_cycle();
  endtask

  task automatic test_spart();
    ex_send = 1; spart_full = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (outs !== SPART) begin n_err++; $display("FAIL spart cyc%0d got %b want %b", i, outs, SPART); end
      next_cycle();
    end
    spart_full = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL spart_release got %b want %b", outs, IDLE); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_priority();
    mem_wait = 1; ex_redirect = 1; ex_send = 1; spart_full = 1;
    @(negedge clk);
    n_cmp++;
    if (outs !== MEMST) begin n_err++; $display("FAIL prio_mem got %b want %b", outs, MEMST); end
    next_cycle();
    mem_wait = 0;
    @(negedge clk);
    n_cmp++;
    if (outs !== FLUSH) begin n_err++; $display("FAIL prio_redirect got %b want %b", outs, FLUSH); end
    next_cycle();
    clear_inputs();
    ex_send = 1; spart_full = 1; accel_busy = 1; id_accel_req = 1;
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL prio_redirect_idle got %b want %b", outs, IDLE); end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (outs !== SPART) begin n_err++; $display("FAIL prio_spart got %b want %b", outs, SPART); end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_async_reset();
    logic [6:0] exp;
    mem_wait = 1;
    for (int i = 0; i < 5; i++) next_cycle();
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL async_reset got %b want %b", outs, IDLE); end
    mem_wait = 0;
    @(negedge clk);
    rst_n = 1;
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (outs !== IDLE) begin n_err++; $display("FAIL post_reset got %b want %b", outs, IDLE); end
    next_cycle();
    mem_wait = 1;
    for (int i = 1; i <= 15; i++) begin
      exp = (i == 15) ? MEMERR : MEMST;
      @(negedge clk);
      n_cmp++;
      if (outs !== exp) begin n_err++; $display("FAIL post_reset_cnt cyc%0d got %b want %b", i, outs, exp); end
      next_cycle();
    end
    clear_inputs();
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_redirect_accel();
    test_mem_timeout();
    test_spart();
    test_priority();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central hazard and sequencing controller for the 4-stage integer pipeline.
- Drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC hold.
- Resolves load-use hazards, branch/jump redirects, multi-cycle data-memory waits, accelerator busy windows and SPART transmit back-pressure from one prioritised FSM.
- Sits beside the decoder; all outputs are registered-state-derived combinational signals valid in the same cycle.

Parameters:
- REG_AW, 4, register address width (matches dst_addr/p0_addr/p1_addr).
- MEM_TIMEOUT, 15, max consecutive mem_wait cycles before mem_err pulses.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_p0_addr  in  REG_AW  source 0 of instruction in ID.
- id_p1_addr  in  REG_AW  source 1 of instruction in ID.
- id_p0_used, id_p1_used  in  1  each  source actually read.
- ex_dst_addr  in  REG_AW  destination of instruction in EX.
- ex_mem_re  in  1  instruction in EX is a load.
- ex_we  in  1  instruction in EX writes the register file.
- ex_redirect  in  1  EX resolved branch mispredict or taken jump.
- mem_wait  in  1  data memory not ready this cycle.
- accel_busy  in  1  accelerator occupied.
- id_accel_req  in  1  instruction in ID targets accelerator.
- spart_full  in  1  SPART TX FIFO full.
- ex_send  in  1  instruction in EX sends to SPART.
- pc_hold  out  1  freeze PC.
- if_id_stall, if_id_flush  out  1  each.
- id_ex_stall, id_ex_flush  out  1  each.
- ex_mem_stall  out  1.
- mem_err  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset (rst_n low, async): state=RUN, wait counter=0, mem_err=0; all stall/flush outputs 0.
- States: RUN, MEM_WAIT, ACCEL_WAIT, SPART_WAIT, REDIRECT.
- Priority each cycle, highest first: mem_wait > ex_redirect > spart back-pressure > accelerator > load-use.
- mem_wait=1 (any state): enter/stay MEM_WAIT; pc_hold, if_id_stall, id_ex_stall, ex_mem_stall all 1; no flushes. Counter increments; at count==MEM_TIMEOUT, pulse mem_err for 1 cycle, clear counter, remain stalled while mem_wait holds. mem_wait=0 → RUN, counter cleared.
- ex_redirect=1 with mem_wait=0: if_id_flush=1, id_ex_flush=1 same cycle; no stalls (PC loads target). Next cycle REDIRECT: outputs idle, then RUN. A redirect during a pending load-use/accel stall overrides it (flush wins, stall outputs 0).
- ex_send & spart_full: SPART_WAIT; pc_hold, if_id_stall, id_ex_stall=1; ex_mem_stall=0. Exit the cycle spart_full=0.
- id_accel_req & accel_busy: ACCEL_WAIT; pc_hold, if_id_stall=1, id_ex_flush=1 (bubble); exit when accel_busy=0.
- Load-use (RUN only): ex_mem_re & ex_we & ((id_p0_used & id_p0_addr==ex_dst_addr) | (id_p1_used & id_p1_addr==ex_dst_addr)) & ex_dst_addr!=0 → exactly one cycle pc_hold, if_id_stall, id_ex_flush; never two consecutive cycles for the same instruction.
- Register address 0 never causes a hazard.
- Simultaneous flush and stall on the same register never asserted.
- Latency: all decisions combinational from inputs + state; state updates on posedge clk.
- Reset mid-stall: returns to RUN immediately; no residual pulses.

Optional Feature:
- PIPE_CTRL_STATS_EN: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt counts cycles with pc_hold=1; flush_cnt counts cycles with id_ex_flush=1.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg: state enum encoding (RUN=0, MEM_WAIT=1, ACCEL_WAIT=2, SPART_WAIT=3, REDIRECT=4), REG_ZERO constant, priority constants.
- Sub-module hazard_detect: pure combinational load-use comparator; FSM and counters stay in pipe_ctrl.

Test Plan:
- Load-use: ex_mem_re=1, ex_we=1, ex_dst_addr=4'h3, id_p1_addr=4'h3, id_p1_used=1 → single cycle pc_hold=1, if_id_stall=1, id_ex_flush=1; next cycle all 0.
- Same stimulus with ex_dst_addr=0 → no stall.
- Redirect during accel wait: accel_busy=1, id_accel_req=1 for 2 cycles, then ex_redirect=1 → that cycle if_id_flush=id_ex_flush=1, pc_hold=0; one REDIRECT cycle, then RUN.
- Memory timeout: mem_wait held 20 cycles → all stalls high for 20 cycles; mem_err pulses on cycle 15 only; RUN on cycle 21.
- SPART: ex_send=1, spart_full=1 for 3 cycles → pc_hold, if_id_stall, id_ex_stall=1 for 3 cycles with ex_mem_stall=0; released when spart_full falls.
- Async reset: assert rst_n=0 mid MEM_WAIT between clock edges → all outputs 0 immediately; state=RUN after release.
